// File: rtl/char_target_queue_pkg.sv
// ============================================================================
// char_target_queue_pkg -- game state encodings and character-code helpers
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package char_target_queue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } game_state_e;

  // Shared with the random-character generator.
  localparam int unsigned GAME_MAX_CODE = 70;

  function automatic logic code_legal(input logic [7:0] code, input int unsigned max_code);
    return (code != 8'd0) && ({24'd0, code} <= max_code);
  endfunction

endpackage

`default_nettype wire

// File: rtl/char_target_queue_fifo.sv
// ============================================================================
// char_fifo -- circular target buffer with push, pop and drop-oldest-on-full
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module char_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW  = $clog2(DEPTH),
  localparam int CW  = AW + 1
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             valid
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             full_q, valid_q;
  logic             do_pop, drop;

  always_comb begin
    do_pop  = pop && (count_q != '0);
    drop    = push && !do_pop && (count_q == CW'(DEPTH));
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (do_pop || drop) rd_d = rd_q + AW'(1);
    if (push)           wr_d = wr_q + AW'(1);
    if (push && !do_pop && !drop) count_d = count_q + CW'(1);
    else if (do_pop && !push)     count_d = count_q - CW'(1);
    // Head is precomputed so it lands in the same cycle as count; a slot
    // written this edge is read from din since mem_q still holds the old data.
    if (count_d == '0)               head_d = '0;
    else if (push && (rd_d == wr_q)) head_d = din;
    else                             head_d = mem_q[rd_d];
    if (clear) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
      head_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
      full_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (push && !clear) mem_q[wr_q] <= din;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      head_q  <= head_d;
      full_q  <= (count_d == CW'(DEPTH));
      valid_q <= (count_d != '0);
    end
  end

  assign head  = head_q;
  assign count = count_q;
  assign full  = full_q;
  assign valid = valid_q;

endmodule

`default_nettype wire

// File: rtl/char_target_queue.sv
// ============================================================================
// char_target_queue -- on-screen target queue, keystroke matching and game FSM
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module char_target_queue
  import char_target_queue_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int LIVES    = 3,
  parameter int MAX_CODE = GAME_MAX_CODE,
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          start,
  input  logic          spawn,
  input  logic [7:0]    rd_char,
  input  logic          key_valid,
  input  logic [7:0]    key_code,
  output logic [7:0]    head_char,
  output logic          head_valid,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          hit,
  output logic          miss,
  output logic          escape,
  output logic [15:0]   hit_cnt,
  output logic [15:0]   miss_cnt,
  output logic [3:0]    lives_left,
  output logic [1:0]    state
);

  game_state_e state_q, state_d;
  logic [3:0]  lives_q, lives_d;
  logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic        hit_q, miss_q, escape_q;
  logic        run, spawn_ok, key_ok, is_hit, is_miss, is_escape;
  logic [7:0]  fifo_head;
  logic        fifo_full, fifo_valid;

  char_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .clear (start),
    .push  (spawn_ok),
    .pop   (is_hit),
    .din   (rd_char),
    .head  (fifo_head),
    .count (count),
    .full  (fifo_full),
    .valid (fifo_valid)
  );

  // A start in the same cycle discards any spawn or keystroke.
  always_comb begin
    run       = (state_q == ST_RUN) && !start;
    spawn_ok  = run && spawn && code_legal(rd_char, MAX_CODE);
    key_ok    = run && key_valid && code_legal(key_code, MAX_CODE);
    is_hit    = key_ok && fifo_valid && (key_code == fifo_head);
    is_miss   = key_ok && !is_hit;
    is_escape = spawn_ok && fifo_full && !is_hit;

    state_d    = state_q;
    lives_d    = lives_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (start) begin
      state_d    = ST_RUN;
      lives_d    = 4'(LIVES);
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else begin
      if (is_hit && (hit_cnt_q != 16'hFFFF))   hit_cnt_d  = hit_cnt_q + 16'd1;
      if (is_miss && (miss_cnt_q != 16'hFFFF)) miss_cnt_d = miss_cnt_q + 16'd1;
      if (is_escape) begin
        lives_d = lives_q - 4'd1;
        if (lives_q == 4'd1) state_d = ST_OVER;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= ST_IDLE;
      lives_q    <= 4'(LIVES);
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      escape_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      hit_q      <= is_hit;
      miss_q     <= is_miss;
      escape_q   <= is_escape;
    end
  end

  assign head_char  = fifo_head;
  assign head_valid = fifo_valid;
  assign full       = fifo_full;
  assign hit        = hit_q;
  assign miss       = miss_q;
  assign escape     = escape_q;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;
  assign lives_left = lives_q;
  assign state      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_char_target_queue.sv
// ============================================================================
// tb_char_target_queue -- scenario and randomized checks against a queue model
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_char_target_queue;

  localparam int DEPTH = 8;
  localparam int LIVES = 3;
  localparam int MAXC  = 70;

  logic        clk = 1'b0;
  logic        clrn, start, spawn, key_valid;
  logic [7:0]  rd_char, key_code;
  logic [7:0]  head_char;
  logic        head_valid, full, hit, miss, escape;
  logic [3:0]  count, lives_left;
  logic [15:0] hit_cnt, miss_cnt;
  logic [1:0]  state;

  char_target_queue #(.DEPTH(DEPTH), .LIVES(LIVES), .MAX_CODE(MAXC)) dut (
    .clk(clk), .clrn(clrn), .start(start), .spawn(spawn), .rd_char(rd_char),
    .key_valid(key_valid), .key_code(key_code), .head_char(head_char),
    .head_valid(head_valid), .count(count), .full(full), .hit(hit), .miss(miss),
    .escape(escape), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .lives_left(lives_left), .state(state)
  );

  always #5 clk = ~clk;

  wire [54:0] dut_vec = {head_char, head_valid, count, full, hit, miss, escape,
                         hit_cnt, miss_cnt, lives_left, state};

  // Behavioural model: a queue of targets plus game bookkeeping.
  logic [7:0] mq[$];
  bit         m_hit, m_miss, m_esc;
  int         m_hcnt, m_mcnt, m_lives, m_state;
  int         n_checks = 0;
  int         n_fail   = 0;

  function logic [54:0] exp_vec();
    logic [7:0] h;
    h = (mq.size() != 0) ? mq[0] : 8'd0;
    return {h, (mq.size() != 0), 4'(mq.size()), (mq.size() == DEPTH), m_hit, m_miss,
            m_esc, 16'(m_hcnt), 16'(m_mcnt), 4'(m_lives), 2'(m_state)};
  endfunction

  task automatic model_reset();
    mq.delete();
    {m_hit, m_miss, m_esc} = 3'b000;
    m_hcnt = 0; m_mcnt = 0; m_lives = LIVES; m_state = 0;
  endtask

  task automatic model_step(input bit st, input bit sp, input logic [7:0] rc,
                            input bit kv, input logic [7:0] kc);
    bit sp_ok, kv_ok;
    {m_hit, m_miss, m_esc} = 3'b000;
    if (st) begin
      mq.delete(); m_hcnt = 0; m_mcnt = 0; m_lives = LIVES; m_state = 1;
      return;
    end
    if (m_state != 1) return;
    sp_ok = sp && rc >= 1 && rc <= MAXC;
    kv_ok = kv && kc >= 1 && kc <= MAXC;
    if (kv_ok) begin
      if (mq.size() != 0 && kc == mq[0]) begin
        void'(mq.pop_front()); m_hit = 1; if (m_hcnt < 65535) m_hcnt++;
      end else begin
        m_miss = 1; if (m_mcnt < 65535) m_mcnt++;
      end
    end
    if (sp_ok) begin
      if (mq.size() == DEPTH) begin
        void'(mq.pop_front()); m_esc = 1; m_lives--;
        if (m_lives == 0) m_state = 2;
      end
      mq.push_back(rc);
    end
  endtask

  task automatic drive(input bit st, input bit sp, input logic [7:0] rc,
                       input bit kv, input logic [7:0] kc);
    start = st; spawn = sp; rd_char = rc; key_valid = kv; key_code = kc;
    @(posedge clk);
    model_step(st, sp, rc, kv, kc);
    #1;
    start = 0; spawn = 0; rd_char = 0; key_valid = 0; key_code = 0;
  endtask

  task automatic test_reset();
    clrn = 0; start = 0; spawn = 0; rd_char = 0; key_valid = 0; key_code = 0;
    model_reset();
    #12;
    n_checks++;
    if (dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", dut_vec, exp_vec());
    end
    @(negedge clk); clrn = 1;
    @(posedge clk); #1;
    drive(0, 1, 8'd5, 1, 8'd5);
    n_checks++;
    if (count !== 4'd0 || state !== 2'd0 || lives_left !== 4'd3 || miss !== 1'b0) begin
      n_fail++; $display("FAIL idle_ignore: got count=%0d state=%0d lives=%0d miss=%0d required 0 0 3 0",
                         count, state, lives_left, miss);
    end
  endtask

  task automatic test_basic();
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 8'd5, 0, 0);
    drive(0, 1, 8'd12, 0, 0);
    drive(0, 1, 8'd70, 0, 0);
    n_checks++;
    if (count !== 4'd3 || head_char !== 8'd5 || state !== 2'd1) begin
      n_fail++; $display("FAIL basic_fill: got count=%0d head=%0d state=%0d required 3 5 1",
                         count, head_char, state);
    end
    drive(0, 0, 0, 1, 8'd5);
    n_checks++;
    if (hit !== 1'b1 || hit_cnt !== 16'd1) begin
      n_fail++; $display("FAIL basic_hit1: got hit=%0d hit_cnt=%0d required 1 1", hit, hit_cnt);
    end
    drive(0, 0, 0, 1, 8'd12);
    n_checks++;
    if (hit !== 1'b1 || hit_cnt !== 16'd2 || head_char !== 8'd70 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL basic_hit2: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_miss();
    drive(0, 0, 0, 1, 8'd9);
    n_checks++;
    if (miss !== 1'b1 || miss_cnt !== 16'd1 || head_char !== 8'd70 || hit !== 1'b0) begin
      n_fail++; $display("FAIL miss_wrong_key: got miss=%0d miss_cnt=%0d head=%0d required 1 1 70",
                         miss, miss_cnt, head_char);
    end
    drive(0, 0, 0, 1, 8'd0);
    n_checks++;
    if (miss !== 1'b0 || miss_cnt !== 16'd1 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL miss_key0: got %h expected %h", dut_vec, exp_vec());
    end
    drive(0, 0, 0, 1, 8'd71);
    n_checks++;
    if (miss !== 1'b0 || hit_cnt !== 16'd2 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL miss_key71: got %h expected %h", dut_vec, exp_vec());
    end
    drive(0, 1, 8'd71, 0, 0);
    n_checks++;
    if (count !== 4'd1 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL spawn_illegal: got count=%0d required 1", count);
    end
  endtask

  task automatic test_escape();
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) drive(0, 1, 8'($urandom_range(1, MAXC)), 0, 0);
    n_checks++;
    if (full !== 1'b1 || count !== 4'd8 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL esc_fill: got %h expected %h", dut_vec, exp_vec());
    end
    for (int i = 0; i < LIVES; i++) begin
      drive(0, 1, 8'(40 + i), 0, 0);
      n_checks++;
      if (escape !== 1'b1 || lives_left !== 4'(LIVES - 1 - i) || count !== 4'd8 ||
          state !== ((i == LIVES - 1) ? 2'd2 : 2'd1)) begin
        n_fail++; $display("FAIL esc_%0d: got esc=%0d lives=%0d count=%0d state=%0d",
                           i, escape, lives_left, count, state);
      end
    end
    drive(0, 1, 8'd10, 1, head_char);
    n_checks++;
    if (escape !== 1'b0 || hit !== 1'b0 || state !== 2'd2 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL over_frozen: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_full_simul();
    drive(1, 0, 0, 0, 0);
    for (int i = 1; i <= DEPTH; i++) drive(0, 1, 8'(i), 0, 0);
    drive(0, 1, 8'd33, 1, 8'd1);
    n_checks++;
    if (hit !== 1'b1 || escape !== 1'b0 || count !== 4'd8 || lives_left !== 4'd3) begin
      n_fail++; $display("FAIL full_spawn_hit: got hit=%0d esc=%0d count=%0d lives=%0d required 1 0 8 3",
                         hit, escape, count, lives_left);
    end
    for (int i = 2; i <= DEPTH; i++) drive(0, 0, 0, 1, 8'(i));
    n_checks++;
    if (head_char !== 8'd33 || count !== 4'd1 || hit_cnt !== 16'd8) begin
      n_fail++; $display("FAIL full_tail: got head=%0d count=%0d hit_cnt=%0d required 33 1 8",
                         head_char, count, hit_cnt);
    end
  endtask

  task automatic test_empty_simul();
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 8'd7, 1, 8'd7);
    n_checks++;
    if (miss !== 1'b1 || hit !== 1'b0 || count !== 4'd1 || head_char !== 8'd7) begin
      n_fail++; $display("FAIL empty_spawn_key: got miss=%0d hit=%0d count=%0d head=%0d required 1 0 1 7",
                         miss, hit, count, head_char);
    end
    drive(1, 1, 8'd20, 1, 8'd7);
    n_checks++;
    if (count !== 4'd0 || hit !== 1'b0 || miss_cnt !== 16'd0 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL start_wins: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    bit st, sp, kv;
    logic [7:0] rc, kc;
    drive(1, 0, 0, 0, 0);
    for (int n = 0; n < 800; n++) begin
      st = (m_state != 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
      sp = $urandom_range(0, 1);
      rc = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(71, 255)) * 8'($urandom_range(0, 1))
                                       : 8'($urandom_range(1, MAXC));
      kv = $urandom_range(0, 1);
      kc = ($urandom_range(0, 1) && mq.size() != 0) ? mq[0] : 8'($urandom_range(0, 75));
      drive(st, sp, rc, kv, kc);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random_%0d: got %h expected %h", n, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_saturation();
    drive(1, 0, 0, 0, 0);
    key_valid = 1; key_code = 8'd9;
    repeat (65535) @(posedge clk);
    #1;
    key_valid = 0; key_code = 0;
    m_mcnt = 65535; m_miss = 1;
    n_checks++;
    if (miss_cnt !== 16'hFFFF || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL sat_reach: got miss_cnt=%h required ffff", miss_cnt);
    end
    drive(0, 0, 0, 1, 8'd9);
    n_checks++;
    if (miss !== 1'b1 || miss_cnt !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_hold: got miss=%0d miss_cnt=%h required 1 ffff", miss, miss_cnt);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 8'd15, 0, 0);
    drive(0, 1, 8'd16, 1, 8'd3);
    #2 clrn = 0;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec !== exp_vec() || count !== 4'd0 || state !== 2'd0) begin
      n_fail++; $display("FAIL async_reset: got %h expected %h", dut_vec, exp_vec());
    end
    @(negedge clk); clrn = 1;
    @(posedge clk); #1;
    n_checks++;
    if (state !== 2'd0 || lives_left !== 4'd3 || head_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset: got state=%0d lives=%0d valid=%0d required 0 3 0",
                         state, lives_left, head_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_miss();
    test_escape();
    test_full_simul();
    test_empty_simul();
    test_random();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/char_target_queue.md
# char_target_queue

Consumer end of the random-character path in the typing game. Accepts printable character codes, encoded 1..70, from the random-character generator whenever the game's spawn tick fires. Holds them oldest-first as the on-screen targets and matches decoded keystrokes, in the same 1..70 encoding, against the oldest target. Publishes the head target, the queue occupancy, hit/miss/escape statistics and a small game state machine to the display and score logic.

## Interface
Parameters:
- DEPTH, 8: number of simultaneous targets; power of two, 2..16.
- LIVES, 3: escapes allowed before game over; 1..15.
- MAX_CODE, 70: largest legal character code; legal range is 1..MAX_CODE.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- clrn  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse; begin a new game.
- spawn  in  1  one-cycle pulse; push rd_char as a new target.
- rd_char  in  8  code from the random-character generator.
- key_valid  in  1  one-cycle pulse; key_code is a new keystroke.
- key_code  in  8  decoded keystroke code.
- head_char  out  8  oldest target code; 0 when empty.
- head_valid  out  1  queue non-empty.
- count  out  $clog2(DEPTH)+1  occupancy.
- full  out  1  count == DEPTH.
- hit  out  1  one-cycle pulse; keystroke matched head.
- miss  out  1  one-cycle pulse; keystroke did not match.
- escape  out  1  one-cycle pulse; a target was dropped by overflow.
- hit_cnt  out  16  hits, saturating at 16'hFFFF.
- miss_cnt  out  16  misses, saturating.
- lives_left  out  4  remaining lives.
- state  out  2  game state: 0 IDLE, 1 RUN, 2 OVER.

## Operation
- Reset or IDLE entry values:
  - queue empty; head_char=0; head_valid=0; count=0; full=0.
  - all pulses 0; hit_cnt=0; miss_cnt=0.
  - lives_left=LIVES; state=IDLE.
- FSM transitions:
  - IDLE --start--> RUN: clears queue and counters, reloads lives_left.
  - RUN --escape that takes lives_left to 0--> OVER.
  - OVER --start--> RUN: same clearing as IDLE→RUN.
  - start while already in RUN restarts the game with the same clearing.
- Outside RUN, spawn and key_valid are ignored. Queue and counters are frozen; in OVER they keep their final values for the score display.
- Spawn rules, RUN only:
  - spawn is accepted only if 1 ≤ rd_char ≤ MAX_CODE; otherwise it is ignored.
  - Accepted spawn with count < DEPTH: push at the tail.
  - Accepted spawn with queue full: drop the oldest target, push the new one (count unchanged), pulse escape, decrement lives_left.
- Keystroke rules, RUN only:
  - key_code outside 1..MAX_CODE is ignored, with no miss.
  - Queue empty: any legal key is a miss.
  - key_code == head_char: pop the head, pulse hit, increment hit_cnt.
  - key_code != head_char: pulse miss, increment miss_cnt; queue unchanged.
- Simultaneous events in one cycle:
  - Spawn and hit, not full: pop and push together; count unchanged.
  - Spawn and hit, full: the hit pops the head, the spawn pushes; no escape.
  - Spawn and miss: both take effect independently.
  - start with spawn or key in the same cycle: start wins and the others are discarded.
- Matching always uses the pre-cycle head. A character spawned this cycle cannot be hit this cycle, even into an empty queue.
- Storage is a circular buffer: read and write pointers wrap modulo DEPTH, plus a separate occupancy counter.

## Timing
- Every output is registered. The effect of an event at edge N is visible after edge N, with one-cycle latency.
- Each pulse output is high for exactly one cycle per event.
- head_char and head_valid update in the same cycle as count.
- clrn asserted mid-game returns all outputs to their reset values immediately, with no dependence on clk.
- Deassertion of clrn is assumed synchronised upstream.

## Structure
- Shared game package holds:
  - state encodings IDLE/RUN/OVER;
  - the MAX_CODE constant of 70, shared with the generator;
  - a legal-code check function.
- One sub-module, char_fifo, provides the circular buffer. It has push, pop, drop-on-full, head, count and full, with simultaneous push/pop support.
- The FSM, match compare and saturating counters live in the top level.

## Test plan
- Reset, start, then spawn 5, 12, 70 -> count=3, head_char=5; keys 5, 12 -> two hit pulses, hit_cnt=2, head_char=70.
- Key 9 with head 70 -> miss=1, miss_cnt=1, head stays 70; key 0 or key 71 -> no miss, counters unchanged.
- Fill 8 targets, then spawn with LIVES=3 three times -> three escape pulses; state=OVER after the third; later spawn and key are ignored.
- Full queue, spawn 33 and key equal to head in the same cycle -> hit=1, escape=0, count=8, tail=33.
- Empty queue, spawn 7 and key 7 in the same cycle -> miss=1, count=1, head_char=7.
- Force miss_cnt to 16'hFFFF and press a wrong key -> it stays 16'hFFFF. Assert clrn mid-game -> all outputs reset without a clock edge.
